// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: receiver FSM states, frame constants
// and the baud tick divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    localparam int DATA_BITS          = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    // Clocks per oversample tick, rounded down.
    function automatic int tick_div(input int clk_freq, input int baud, input int oversample);
        return clk_freq / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Free-running oversample tick generator: one-clk tick every DIV clocks.
// Only reset restarts it, so receiver and transmitter can share the same phase.
module uart_tick_gen #(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_char_receiver.sv
// 8N1 UART receiver producing one character-write strobe (cout + we) per good
// frame, directly compatible with the VGA controller's character input.
module uart_char_receiver
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] cout,
    output logic                 we,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TICK_DIV = tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
    localparam int SC_W     = $clog2(OVERSAMPLE);
    localparam int BC_W     = $clog2(DATA_BITS + 1);

    localparam logic [SC_W-1:0] SC_MID  = SC_W'(OVERSAMPLE / 2 - 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(OVERSAMPLE - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(DATA_BITS - 1);

    logic                 rx_meta;
    logic                 rx_s;
    logic                 tick;

    rx_state_t            state;
    rx_state_t            state_next;
    logic [SC_W-1:0]      scnt;
    logic [SC_W-1:0]      scnt_next;
    logic [BC_W-1:0]      bit_cnt;
    logic [BC_W-1:0]      bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [DATA_BITS-1:0] cout_next;
    logic                 we_next;
    logic                 ferr_next;

    uart_tick_gen #(
        .DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Two-flop synchroniser; reset to the idle line level so no false start.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            scnt      <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            cout      <= '0;
            we        <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            scnt      <= scnt_next;
            bit_cnt   <= bit_cnt_next;
            shift_reg <= shift_next;
            cout      <= cout_next;
            we        <= we_next;
            frame_err <= ferr_next;
            busy      <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next   = state;
        scnt_next    = scnt;
        bit_cnt_next = bit_cnt;
        shift_next   = shift_reg;
        cout_next    = cout;
        we_next      = 1'b0;
        ferr_next    = 1'b0;

        if (tick) begin
            unique case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_next = START;
                        scnt_next  = '0;
                    end
                end

                // Re-check the line at mid start bit to reject short glitches.
                START: begin
                    if (scnt == SC_MID) begin
                        scnt_next = '0;
                        if (!rx_s) begin
                            state_next   = DATA;
                            bit_cnt_next = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        scnt_next = scnt + 1'b1;
                    end
                end

                DATA: begin
                    if (scnt == SC_LAST) begin
                        scnt_next    = '0;
                        shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt_next = bit_cnt + 1'b1;
                        if (bit_cnt == BC_LAST) begin
                            state_next = STOP;
                        end
                    end else begin
                        scnt_next = scnt + 1'b1;
                    end
                end

                // Leaving at mid stop bit leaves half a bit to catch a following start.
                STOP: begin
                    if (scnt == SC_LAST) begin
                        scnt_next = '0;
                        if (rx_s) begin
                            cout_next  = shift_reg;
                            we_next    = 1'b1;
                            state_next = IDLE;
                        end else begin
                            ferr_next  = 1'b1;
                            state_next = WAIT_HIGH;
                        end
                    end else begin
                        scnt_next = scnt + 1'b1;
                    end
                end

                WAIT_HIGH: begin
                    if (rx_s) begin
                        state_next = IDLE;
                    end
                end

                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_char_receiver.sv
// Scoreboard bench for uart_char_receiver: frames are driven serially, expected
// characters and framing errors are queued, and a monitor checks each strobe.
module tb_uart_char_receiver;

    localparam int CLK_FREQ   = 1_600_000;
    localparam int BAUD       = 10_000;
    localparam int OVERSAMPLE = 16;
    localparam int BIT_CLKS   = 160;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx;
    logic [7:0] cout;
    logic       we;
    logic       frame_err;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         ferr_pending = 0;
    int         cycle = 0;
    int         prev_we_cycle = -1;
    int         last_we_cycle = -1;
    logic       we_prev = 1'b0;

    uart_char_receiver #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .cout      (cout),
        .we        (we),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    task automatic idle(input int clks);
        rx = 1'b1;
        repeat (clks) @(negedge clk);
    endtask

    // Drives one 8N1 frame LSB first; the line is left at the stop level.
    task automatic applyStimulus(input logic [7:0] data, input int period, input logic stop_level);
        if (stop_level) exp_q.push_back(data);
        else            ferr_pending++;
        rx = 1'b0;
        repeat (period) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            repeat (period) @(negedge clk);
        end
        rx = stop_level;
        repeat (period) @(negedge clk);
    endtask

    // Monitor: pops the scoreboard on every strobe the DUT presents.
    always @(negedge clk) begin
        if (!reset) begin
            if (we) begin
                checkOutput("we_pulse_width", {31'd0, we_prev}, 32'd0);
                checkOutput("we_ferr_exclusive", {31'd0, frame_err}, 32'd0);
                checkOutput("busy_at_we", {31'd0, busy}, 32'd0);
                checkOutput("we_expected", exp_q.size(), 32'd1);
                if (exp_q.size() > 0) begin
                    checkOutput("cout_at_we", {24'd0, cout}, {24'd0, exp_q.pop_front()});
                end
                if (!we_prev) begin
                    prev_we_cycle = last_we_cycle;
                    last_we_cycle = cycle;
                end
            end
            if (frame_err) begin
                checkOutput("ferr_expected", ferr_pending, 32'd1);
                checkOutput("busy_at_ferr", {31'd0, busy}, 32'd1);
                if (ferr_pending > 0) ferr_pending--;
            end
        end
        we_prev = we;
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation did not complete, cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int spacing;
        reset = 1'b1;
        rx    = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_cout", {24'd0, cout}, 32'h00);
        checkOutput("reset_we", {31'd0, we}, 32'd0);
        checkOutput("reset_ferr", {31'd0, frame_err}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        idle(BIT_CLKS);

        $display("[TB] single frame 0x41");
        applyStimulus(8'h41, BIT_CLKS, 1'b1);
        idle(2 * BIT_CLKS);
        checkOutput("t1_cout", {24'd0, cout}, 32'h41);
        checkOutput("t1_busy_idle", {31'd0, busy}, 32'd0);

        $display("[TB] back-to-back 0x48 0x69");
        applyStimulus(8'h48, BIT_CLKS, 1'b1);
        applyStimulus(8'h69, BIT_CLKS, 1'b1);
        idle(2 * BIT_CLKS);
        spacing = last_we_cycle - prev_we_cycle;
        checkOutput("t2_we_spacing_ok", {31'd0, (spacing >= 1500 && spacing <= 1700)}, 32'd1);
        checkOutput("t2_cout", {24'd0, cout}, 32'h69);

        $display("[TB] framing error 0x55 then 0x0D");
        applyStimulus(8'h55, BIT_CLKS, 1'b0);
        repeat (800) @(negedge clk);
        checkOutput("t3_busy_in_break", {31'd0, busy}, 32'd1);
        rx = 1'b1;
        checkOutput("t3_cout_held", {24'd0, cout}, 32'h69);
        idle(BIT_CLKS);
        applyStimulus(8'h0D, BIT_CLKS, 1'b1);
        idle(2 * BIT_CLKS);
        checkOutput("t3_cout_new", {24'd0, cout}, 32'h0D);

        $display("[TB] start glitch then 0x21");
        rx = 1'b0;
        repeat (30) @(negedge clk);
        rx = 1'b1;
        for (int i = 0; i < 70 && busy; i++) @(negedge clk);
        checkOutput("t4_busy_cleared", {31'd0, busy}, 32'd0);
        idle(BIT_CLKS);
        applyStimulus(8'h21, BIT_CLKS, 1'b1);
        idle(2 * BIT_CLKS);
        checkOutput("t4_cout", {24'd0, cout}, 32'h21);

        $display("[TB] reset during data bit 4 of 0xFF");
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        checkOutput("t5_busy_before_reset", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("t5_reset_cout", {24'd0, cout}, 32'h00);
        checkOutput("t5_reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("t5_reset_we", {31'd0, we}, 32'd0);
        idle(BIT_CLKS / 2 + 4 * BIT_CLKS + BIT_CLKS);
        applyStimulus(8'h7A, BIT_CLKS, 1'b1);
        idle(2 * BIT_CLKS);
        checkOutput("t5_cout", {24'd0, cout}, 32'h7A);

        $display("[TB] baud tolerance 0xA5 at +3%% and -3%%");
        applyStimulus(8'hA5, 165, 1'b1);
        idle(2 * BIT_CLKS);
        checkOutput("t6_cout_slow", {24'd0, cout}, 32'hA5);
        applyStimulus(8'h5A, 155, 1'b1);
        idle(2 * BIT_CLKS);
        applyStimulus(8'hA5, 155, 1'b1);
        idle(2 * BIT_CLKS);
        checkOutput("t6_cout_fast", {24'd0, cout}, 32'hA5);

        idle(400);
        checkOutput("scoreboard_empty", exp_q.size(), 32'd0);
        checkOutput("ferr_all_seen", ferr_pending, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
